// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, with optional
// repetition, an idle gap between frames, sticky STOP handling and a DONE pulse.
module seq_pattern_tx #(
  parameter int W   = 8,
  parameter int LW  = 4,
  parameter int RW  = 4,
  parameter int GAP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  pat,
  input  logic [LW-1:0] len,
  input  logic [RW-1:0] reps,
  input  logic          stop,
  output logic          sout,
  output logic          valid,
  output logic          first,
  output logic          busy,
  output logic          done
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LW:0] WMAX = (LW + 1)'(W);

  typedef enum logic [1:0] {IDLE, SEND, GAPW, FIN} state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  pat_reg, pat_next;
  logic [LW-1:0] len_reg, len_next;
  logic [RW-1:0] reps_reg, reps_next;
  logic [LW-1:0] idx_reg, idx_next;
  logic [RW-1:0] cnt_reg, cnt_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic          stop_reg, stop_next;

  logic sout_reg, sout_next;
  logic valid_reg, valid_next;
  logic first_reg, first_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;

  logic          len_ok;
  logic          last_frame;
  logic [W-1:0]  shifted;

  assign len_ok = (len != '0) && ({1'b0, len} <= WMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pat_reg   <= '0;
      len_reg   <= '0;
      reps_reg  <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      gap_reg   <= '0;
      stop_reg  <= 1'b0;
      sout_reg  <= 1'b0;
      valid_reg <= 1'b0;
      first_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      reps_reg  <= reps_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      gap_reg   <= gap_next;
      stop_reg  <= stop_next;
      sout_reg  <= sout_next;
      valid_reg <= valid_next;
      first_reg <= first_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    reps_next  = reps_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    gap_next   = gap_reg;
    stop_next  = stop_reg;
    last_frame = 1'b0;

    case (state_reg)
      IDLE: begin
        stop_next = 1'b0;
        if (start && len_ok) begin
          pat_next   = pat;
          len_next   = len;
          reps_next  = reps;
          idx_next   = LW'(len - LW'(1));
          cnt_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (stop) stop_next = 1'b1;
        if (idx_reg == '0) begin
          cnt_next   = cnt_reg + RW'(1);
          last_frame = (reps_reg != '0) && (cnt_next == reps_reg);
          // The live stop input counts too, so a STOP on the last bit ends here.
          if (last_frame || stop_reg || stop) begin
            state_next = FIN;
          end else if (GAP == 0) begin
            idx_next = LW'(len_reg - LW'(1));
          end else begin
            gap_next   = GW'(GAP - 1);
            state_next = GAPW;
          end
        end else begin
          idx_next = idx_reg - LW'(1);
        end
      end
      GAPW: begin
        if (stop) begin
          stop_next  = 1'b1;
          state_next = FIN;
        end else if (gap_reg == '0) begin
          idx_next   = LW'(len_reg - LW'(1));
          state_next = SEND;
        end else begin
          gap_next = gap_reg - GW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered: derive them from the state being entered.
    shifted    = pat_next >> idx_next;
    valid_next = (state_next == SEND);
    sout_next  = valid_next & shifted[0];
    first_next = valid_next && (idx_next == LW'(len_next - LW'(1)));
    busy_next  = (state_next == SEND) || (state_next == GAPW);
    done_next  = (state_next == FIN);
  end

  assign sout  = sout_reg;
  assign valid = valid_reg;
  assign first = first_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed table, corner sequences and randomized
// transactions checked cycle by cycle against a frame-level reference model.
module tb_seq_pattern_tx;
  localparam int W   = 8;
  localparam int LW  = 4;
  localparam int RW  = 4;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] pat = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic       sout, valid, first, busy, done;

  always #5 clk = ~clk;

  seq_pattern_tx #(.W(W), .LW(LW), .RW(RW), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pat(pat), .len(len),
    .reps(reps), .stop(stop), .sout(sout), .valid(valid), .first(first),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [7:0] pat;
    int         len;
    int         reps;
    int         stop_cyc;
    int         hit;
    bit         dstart;
    int         exp_done;
    int         exp_frames;
  } vec_t;

  vec_t       tbl[8];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [4:0] exp_q[$];

  function automatic logic [4:0] outs();
    return {sout, valid, first, busy, done};
  endfunction

  task automatic check(input string name, input int cyc, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h, required %0h", name, cyc, got, want);
    end
  endtask

  // Expected per-cycle {sout,valid,first,busy,done}, starting at cycle 1.
  task automatic build_model(input logic [7:0] p, input int l, input int r, input int sc);
    int  c = 1;
    int  f = 0;
    int  fs;
    bit  ended = 0;
    exp_q.delete();
    while (!ended && f < 64) begin
      f++;
      fs = c;
      for (int b = l - 1; b >= 0; b--) begin
        exp_q.push_back({p[b], 1'b1, (b == l - 1), 1'b1, 1'b0});
        c++;
      end
      if ((r != 0 && f == r) || (sc >= fs && sc < c)) break;
      for (int g = 0; g < GAP; g++) begin
        exp_q.push_back(5'b00010);
        c++;
        if (c - 1 == sc) begin
          ended = 1;
          break;
        end
      end
    end
    exp_q.push_back(5'b00001);
  endtask

  task automatic run_tx(input logic [7:0] p, input int l, input int r, input int sc,
                        input int hit, input bit dstart, input bit scramble,
                        output int done_cyc, output int frames);
    int n;
    build_model(p, l, r, sc);
    n = exp_q.size();
    start = 1'b1; pat = p; len = 4'(l); reps = 4'(r); stop = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1;
    frames = 0;
    for (int i = 0; i < n; i++) begin
      check("outputs", i + 1, int'(outs()), int'(exp_q[i]));
      if (done && done_cyc < 0) done_cyc = i + 1;
      if (first && valid) frames++;
      stop  = (i + 1 == sc);
      start = 1'b0;
      if (i + 1 == hit || (i == n - 1 && dstart)) begin
        start = 1'b1; pat = 8'hFF; len = 4'd4; reps = 4'd1;
      end
      if (scramble && $urandom_range(0, 3) == 0) begin
        start = 1'b1; pat = 8'($urandom); len = 4'($urandom); reps = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0;
    check("idle_after_done", n + 1, int'(outs()), 0);
    $display("txn pat=%02h len=%0d reps=%0d stop_cyc=%0d cycles=%0d done_at=%0d frames=%0d",
             p, l, r, sc, n, done_cyc, frames);
  endtask

  initial begin
    int dc, fr, l, r, sc;
    tbl[0] = '{8'h0B, 4, 1, 0,  0, 1'b0, 5,  1};
    tbl[1] = '{8'hA5, 8, 2, 0,  0, 1'b0, 19, 2};
    tbl[2] = '{8'h0B, 4, 0, 14, 0, 1'b0, 17, 3};
    tbl[3] = '{8'h0B, 4, 1, 0,  3, 1'b0, 5,  1};
    tbl[4] = '{8'h3C, 6, 3, 6,  0, 1'b1, 7,  1};
    tbl[5] = '{8'h01, 1, 3, 0,  0, 1'b0, 8,  3};
    tbl[6] = '{8'hC3, 8, 5, 9,  0, 1'b0, 10, 1};
    tbl[7] = '{8'h05, 3, 4, 6,  0, 1'b1, 9,  2};

    #12;
    check("reset_outputs", 0, int'(outs()), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", 0, int'(outs()), 0);

    foreach (tbl[k]) begin
      run_tx(tbl[k].pat, tbl[k].len, tbl[k].reps, tbl[k].stop_cyc, tbl[k].hit,
             tbl[k].dstart, 1'b0, dc, fr);
      check("done_cycle", k, dc, tbl[k].exp_done);
      check("frame_count", k, fr, tbl[k].exp_frames);
    end

    // Illegal lengths: the request must be ignored entirely.
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; pat = 8'hFF; len = (k == 0) ? 4'd0 : 4'd9; reps = 4'd1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        check("illegal_len", c, int'(outs()), 0);
        @(posedge clk); #1;
      end
      $display("txn illegal len=%0d ignored", len);
    end

    // Mid-frame asynchronous reset.
    start = 1'b1; pat = 8'h0B; len = 4'd4; reps = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("pre_reset_bit", 1, int'(outs()), 5'b11110);
    @(posedge clk); #1;
    check("pre_reset_bit", 2, int'(outs()), 5'b01010);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 2, int'(outs()), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("post_reset_idle", c, int'(outs()), 0);
      @(posedge clk); #1;
    end
    $display("txn mid-frame reset");
    run_tx(8'h0B, 4, 1, 0, 0, 1'b0, 1'b0, dc, fr);
    check("restart_done_cycle", 0, dc, 5);

    // Randomized transactions with input scrambling while busy.
    for (int t = 0; t < 30; t++) begin
      l = $urandom_range(1, 8);
      r = $urandom_range(0, 4);
      if (r == 0) sc = $urandom_range(1, 3 * (l + GAP));
      else if ($urandom_range(0, 1) == 1) sc = $urandom_range(1, r * (l + GAP));
      else sc = 0;
      run_tx(8'($urandom), l, r, sc, 0, 1'b0, 1'b1, dc, fr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: latches a parallel pattern of up to W bits and shifts it out MSB-first, one bit per clock, with optional repetition and an idle gap between frames. It is the stimulus source for the team's serial sequence detectors. For example, PAT=4'b1011 with LEN=4 produces the 1011 bit stream such a detector recognises. It sits between a control/register block (START/PAT/LEN/REPS) and the serial input of the downstream detector.

## Interface
- W, default 8: maximum pattern width in bits.
- LW, default 4: width of LEN; must satisfy 2^LW > W.
- RW, default 4: width of REPS.
- GAP, default 2: idle cycles between repeated frames; 0 is legal and means back-to-back frames.
- CK  in  1  clock; all state changes on the rising edge.
- RN  in  1  reset; asynchronous, active-low.
- START  in  1  request; sampled only in IDLE.
- PAT  in  W  pattern; bit LEN-1 is sent first, bit 0 last.
- LEN  in  LW  number of bits per frame; legal range 1..W.
- REPS  in  RW  frame count; 0 means continuous until STOP.
- STOP  in  1  ends transmission after the current frame.
- SOUT  out  1  serial data; 0 whenever VALID=0.
- VALID  out  1  SOUT carries a pattern bit this cycle.
- FIRST  out  1  marks the first bit of every frame.
- BUSY  out  1  transmission in progress.
- DONE  out  1  one-cycle pulse when transmission completes.

## Operation
- States:
  - IDLE
  - SEND, with bit index counting LEN-1 down to 0
  - GAPW, with gap counter
  - FIN
- IDLE:
  - START=1 with 1≤LEN≤W latches PAT, LEN and REPS into internal registers and moves to SEND.
  - START with LEN=0 or LEN>W is ignored: the block stays in IDLE and does not pulse DONE.
- SEND:
  - SOUT = latched PAT[idx], VALID=1.
  - FIRST=1 only when idx=LEN-1.
- After the bit with idx=0:
  - If this was the final frame, or STOP has been seen since the frame started, go to FIN.
  - Otherwise go to GAPW, or go directly to SEND with idx=LEN-1 when GAP=0.
- The frame counter increments on each completed frame. The final frame is the one where the count equals the latched REPS, with REPS≠0.
- GAPW: VALID=0 for exactly GAP cycles, then SEND with idx=LEN-1. STOP seen during GAPW goes to FIN on the next edge.
- STOP is recorded in a sticky flag while in SEND or GAPW. It never truncates a frame in progress. The flag is cleared in IDLE.
- FIN: DONE=1 and BUSY=0 for one cycle, then IDLE unconditionally.
- START, PAT, LEN and REPS changes while BUSY=1 are ignored. The latched copies are used throughout.
- Frame counter width is RW. In continuous mode it does not affect termination and may wrap freely.

## Timing
- Reset (RN=0, asynchronous): state IDLE, all counters and flags cleared, SOUT=VALID=FIRST=BUSY=DONE=0. This applies immediately, including mid-frame. No DONE pulse is produced on release.
- All outputs are registered.
- Latency: START sampled at edge 0 → first bit appears on SOUT in cycle 1 (after edge 0), with BUSY=1.
- A frame occupies LEN consecutive cycles. The gap occupies GAP cycles.
- For REPS=N, DONE falls in cycle N·LEN + (N−1)·GAP + 1.
- BUSY is 1 from cycle 1 through the last bit or gap cycle, and 0 in the DONE cycle.
- A START asserted in the DONE cycle is ignored. A new transmission can begin from a START sampled in the first IDLE cycle after DONE.
- STOP asserted in the same cycle as the last bit of a frame ends transmission after that frame.

## Test plan
- Single frame: PAT=8'h0B, LEN=4, REPS=1, START pulse.
  - Cycles 1–4: SOUT=1,0,1,1, VALID=1; FIRST=1 in cycle 1 only.
  - Cycle 5: DONE=1, BUSY=0. Cycle 6: idle.
- Repeat with gap (GAP=2): PAT=8'hA5, LEN=8, REPS=2.
  - Cycles 1–8: 1,0,1,0,0,1,0,1.
  - Cycles 9–10: VALID=0, SOUT=0.
  - Cycles 11–18: the same 8 bits again; FIRST=1 in cycles 1 and 11.
  - Cycle 19: DONE=1.
- Illegal length: START with LEN=0, then with LEN=9 → BUSY, VALID and DONE all stay 0; the block remains in IDLE.
- Continuous mode: REPS=0, PAT=8'h0B, LEN=4, GAP=2, STOP pulsed in cycle 14 (the 2nd bit of frame 3).
  - Frame 3 completes in cycles 13–16.
  - Cycle 17: DONE=1. No 4th frame is sent.
- Busy protection: during the cycle-3 bit of a LEN=4 frame, assert START with PAT=8'hFF → the output stream is unchanged and no restart occurs.
- Mid-frame reset: assert RN=0 in cycle 2 of a frame.
  - All outputs are 0 immediately.
  - After RN is released, the block is in IDLE with no DONE pulse.
  - A new START then transmits correctly from bit LEN-1.
